// File: rtl/adc_sample_ctrl.sv
// ---------------------------------------------------------------------------
// adc_sample_ctrl
//
// Sequencer for a parallel-output ADC with a convert-start / busy / read
// protocol. Conversions are started at a fixed minimum period while enable
// is high. Each conversion goes through these steps:
//   1. pulse convStart low,
//   2. wait for busy to rise and then fall (this wait is bounded by a timeout),
//   3. pulse rd_cs low for two cycles and take adcVoltage on the second one,
//   4. publish the result on sample with a one-cycle sampleValid pulse.
//
// Optional feature (macro ADC_AVG_EN):
//   When defined, successful reads are summed in a 10-bit accumulator, and
//   every fourth read publishes the mean (accumulator[9:2]). A timeout
//   discards any partial sum. When the macro is undefined there is no
//   accumulator logic at all, and every successful read is published directly.
//
// Parameters:
//   CONV_PERIOD   minimum clk cycles between successive conversion starts (8..255)
//   START_WIDTH   convStart low-pulse width in clk cycles (1..7)
//   BUSY_TIMEOUT  max clk cycles from convStart release to busy falling (4..255)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   enable        high permits new conversions to start
//   busy          ADC conversion in progress (already synchronized)
//   adcVoltage    ADC parallel data, valid while rd_cs is low
//   convStart     ADC conversion start, active low (registered)
//   rd_cs         ADC read / chip select, active low (registered)
//   sample        latest published voltage code (registered)
//   sampleValid   one-cycle pulse when sample updates (registered)
//   timeoutFault  sticky: the last conversion timed out (registered)
//   stateDbg      current FSM state encoding, for observation only
//
// Output handshake: sampleValid is a qualifier with no back-pressure. It is
// high for exactly one cycle, and in that cycle sample holds the new value.
// sample then holds that value until the next pulse or until reset. A
// consumer must take the value in the pulse cycle. There is no ready input.
// ---------------------------------------------------------------------------
module adc_sample_ctrl #(
    parameter int CONV_PERIOD  = 64,
    parameter int START_WIDTH  = 2,
    parameter int BUSY_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       busy,
    input  logic [7:0] adcVoltage,
    output logic       convStart,
    output logic       rd_cs,
    output logic [7:0] sample,
    output logic       sampleValid,
    output logic       timeoutFault,
    output logic [2:0] stateDbg
);

    // Each terminal count is one less than the parameter. The counter starts
    // at 0 on the first cycle of the phase it times.
    localparam logic [7:0] PERIOD_LAST  = 8'(CONV_PERIOD - 1);
    localparam logic [2:0] START_LAST   = 3'(START_WIDTH - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        READ    = 3'd4
    } state_t;

    state_t     state;
    state_t     stateNext;

    logic [7:0] periodCnt;
    logic [2:0] startCnt;
    logic [7:0] timeoutCnt;
    logic       readCnt;

    // Single-cycle events decoded from the FSM. They drive the output registers.
    logic       readDone;
    logic       timedOut;

    logic       inWait;
    logic       stayWait;

    assign stateDbg = state;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        readDone  = 1'b0;
        timedOut  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (periodCnt == PERIOD_LAST)) begin
                    stateNext = START;
                end
            end
            START: begin
                if (startCnt == START_LAST) begin
                    stateNext = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // If busy is already high on the first cycle here, we accept it.
                if (busy) begin
                    stateNext = WAIT_LO;
                end else if (timeoutCnt == TIMEOUT_LAST) begin
                    stateNext = IDLE;
                    timedOut  = 1'b1;
                end
            end
            WAIT_LO: begin
                // If busy falls on the last allowed cycle, the conversion
                // still counts as successful.
                if (!busy) begin
                    stateNext = READ;
                end else if (timeoutCnt == TIMEOUT_LAST) begin
                    stateNext = IDLE;
                    timedOut  = 1'b1;
                end
            end
            READ: begin
                // The second read cycle is the capture cycle.
                if (readCnt) begin
                    stateNext = IDLE;
                    readDone  = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Phase counters
    // -----------------------------------------------------------------------
    assign inWait   = (state == WAIT_HI) || (state == WAIT_LO);
    assign stayWait = (stateNext == WAIT_HI) || (stateNext == WAIT_LO);

    // Free-running period counter. It saturates, so after a long idle stretch
    // the next start can go as soon as enable is high. It restarts from zero
    // at each conversion start, which sets the start-to-start spacing.
    always_ff @(posedge clk) begin
        if (reset) begin
            periodCnt <= '0;
        end else if ((state == IDLE) && (stateNext == START)) begin
            periodCnt <= '0;
        end else if (periodCnt != PERIOD_LAST) begin
            periodCnt <= periodCnt + 8'd1;
        end
    end

    // Counts the cycles already spent in START.
    always_ff @(posedge clk) begin
        if (reset) begin
            startCnt <= '0;
        end else if ((state == START) && (stateNext == START)) begin
            startCnt <= startCnt + 3'd1;
        end else begin
            startCnt <= '0;
        end
    end

    // Timeout counter covers WAIT_HI and WAIT_LO together. Moving from
    // WAIT_HI to WAIT_LO does not restart it, so the limit applies to the
    // whole time from convStart release until busy falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeoutCnt <= '0;
        end else if (inWait && stayWait) begin
            timeoutCnt <= timeoutCnt + 8'd1;
        end else begin
            timeoutCnt <= '0;
        end
    end

    // Selects which of the two read cycles we are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            readCnt <= 1'b0;
        end else if ((state == READ) && (stateNext == READ)) begin
            readCnt <= 1'b1;
        end else begin
            readCnt <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Registered ADC strobes
    // These are decoded from the next state, so the pins change on the same
    // edge as the state register. Because the FSM is in exactly one state,
    // convStart and rd_cs can never both be low.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            convStart <= 1'b1;
            rd_cs     <= 1'b1;
        end else begin
            convStart <= (stateNext != START);
            rd_cs     <= (stateNext != READ);
        end
    end

    // -----------------------------------------------------------------------
    // Fault flag
    // It is set by a timeout and cleared by the next successful read.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            timeoutFault <= 1'b0;
        end else if (timedOut) begin
            timeoutFault <= 1'b1;
        end else if (readDone) begin
            timeoutFault <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Sample publication
    // -----------------------------------------------------------------------
`ifdef ADC_AVG_EN
    logic [9:0] accum;
    logic [1:0] readCount;
    logic [9:0] accumSum;

    // Four 8-bit codes sum to at most 1020, so 10 bits are enough.
    assign accumSum = accum + {2'b00, adcVoltage};

    always_ff @(posedge clk) begin
        if (reset) begin
            sample      <= '0;
            sampleValid <= 1'b0;
            accum       <= '0;
            readCount   <= '0;
        end else begin
            sampleValid <= 1'b0;
            if (timedOut) begin
                // Drop the partial sum so one average never mixes
                // reads from before and after a fault.
                accum     <= '0;
                readCount <= '0;
            end else if (readDone) begin
                if (readCount == 2'd3) begin
                    sample      <= accumSum[9:2];
                    sampleValid <= 1'b1;
                    accum       <= '0;
                    readCount   <= '0;
                end else begin
                    accum     <= accumSum;
                    readCount <= readCount + 2'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            sample      <= '0;
            sampleValid <= 1'b0;
        end else begin
            sampleValid <= readDone;
            if (readDone) begin
                sample <= adcVoltage;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_sample_ctrl
// Directed bench for adc_sample_ctrl with its default parameters. A small
// ADC model answers each convStart release with a busy pulse. It drives valid
// data only during the second rd_cs cycle and junk during the first.
// Expected samples are queued when a conversion is set up. A monitor pops
// the queue on each sampleValid. The monitor also checks pulse widths and
// that convStart and rd_cs are never both low.
// ---------------------------------------------------------------------------
module tb_adc_sample_ctrl;

    localparam int START_W   = 2;
    localparam int PERIOD    = 64;
    localparam int TIMEOUT   = 32;
    localparam logic [7:0] JUNK = 8'hE7;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       busy;
    logic [7:0] adcVoltage;
    logic       convStart;
    logic       rd_cs;
    logic [7:0] sample;
    logic       sampleValid;
    logic       timeoutFault;
    logic [2:0] stateDbg;

    adc_sample_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .busy         (busy),
        .adcVoltage   (adcVoltage),
        .convStart    (convStart),
        .rd_cs        (rd_cs),
        .sample       (sample),
        .sampleValid  (sampleValid),
        .timeoutFault (timeoutFault),
        .stateDbg     (stateDbg)
    );

    // ---------------- clock / reset-relative cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges since reset was released.
    int cyc = 0;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int assertCount = 0;
    int failCount   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- ADC model ----------------
    logic [7:0] curData  = 8'h00;
    bit         busyMode = 1'b1;   // 1: answer with busy, 0: stay silent

    initial begin
        logic convPrevM;
        logic rdPrevM;
        busy       = 1'b0;
        adcVoltage = JUNK;
        convPrevM  = 1'b1;
        rdPrevM    = 1'b1;
        forever begin
            @(negedge clk);
            adcVoltage = (!rd_cs && !rdPrevM) ? curData : JUNK;
            rdPrevM    = rd_cs;
            if (!convPrevM && convStart && busyMode) begin
                repeat (2) @(negedge clk);
                busy = 1'b1;
                repeat (10) @(negedge clk);
                busy = 1'b0;
            end
            convPrevM = convStart;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int convLow = 0, rdLow = 0;
    int convFalls = 0, convRises = 0, rdFalls = 0, rdRises = 0;
    int convFallCyc = 0, convRiseCyc = 0;
    int validCount = 0;
    logic prevValid = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            convLow   = 0;
            rdLow     = 0;
            prevValid = 1'b0;
        end else begin
            check("strobe_overlap", {31'd0, (!convStart && !rd_cs)}, 32'd0);

            if (!convStart) begin
                if (convLow == 0) begin
                    convFalls++;
                    convFallCyc = cyc;
                end
                convLow++;
            end else if (convLow != 0) begin
                check("conv_width", convLow, START_W);
                convLow = 0;
                convRises++;
                convRiseCyc = cyc;
            end

            if (!rd_cs) begin
                if (rdLow == 0) rdFalls++;
                rdLow++;
            end else if (rdLow != 0) begin
                check("rd_width", rdLow, 2);
                rdLow = 0;
                rdRises++;
            end

            if (sampleValid) begin
                validCount++;
                if (prevValid) check("valid_pulse_len", 2, 1);
                if (exp_q.size() == 0) begin
                    check("sample_unexpected", {24'd0, sample}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("sample_value", {24'd0, sample}, {24'd0, e});
                end
            end
            prevValid = sampleValid;
        end
    end

    // ---------------- reference model for published samples ----------------
    logic [9:0] mAcc = '0;
    int         mCnt = 0;

    function automatic void model_read(input logic [7:0] d);
`ifdef ADC_AVG_EN
        mAcc = mAcc + {2'b00, d};
        mCnt++;
        if (mCnt == 4) begin
            exp_q.push_back(mAcc[9:2]);
            mAcc = '0;
            mCnt = 0;
        end
`else
        exp_q.push_back(d);
`endif
    endfunction

    function automatic void model_clear();
        mAcc = '0;
        mCnt = 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fall(output int fc);
        int n0;
        int k;
        n0 = convFalls;
        k  = 0;
        while (convFalls == n0 && k < 300) begin
            tick();
            k++;
        end
        check("conv_start_seen", convFalls - n0, 1);
        fc = convFallCyc;
    endtask

    task automatic wait_read_end();
        int n0;
        int k;
        n0 = rdRises;
        k  = 0;
        while (rdRises == n0 && k < 200) begin
            tick();
            k++;
        end
        check("read_done_seen", rdRises - n0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_convStart"},    {31'd0, convStart},    32'd1);
        check({tag, "_rd_cs"},        {31'd0, rd_cs},        32'd1);
        check({tag, "_sample"},       {24'd0, sample},       32'd0);
        check({tag, "_sampleValid"},  {31'd0, sampleValid},  32'd0);
        check({tag, "_timeoutFault"}, {31'd0, timeoutFault}, 32'd0);
        check({tag, "_state"},        {29'd0, stateDbg},     32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int f0, f1, f2, f3, f4;
        int r0, v0, n0, k, c0, e0;
        logic [7:0] avgData [4];
        avgData[0] = 8'd10;
        avgData[1] = 8'd20;
        avgData[2] = 8'd30;
        avgData[3] = 8'd41;

        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");

        reset  = 1'b0;
        enable = 1'b1;

        // Normal conversions. The counter reaches 63 after 63 edges, and the
        // registered convStart drops on the next edge, edge 64.
        curData = 8'hA5;
        wait_fall(f0);
        check("first_start_cycle", f0, PERIOD);
        model_read(8'hA5);
        wait_read_end();

        curData = 8'h5A;
        wait_fall(f1);
        check("start_period", f1 - f0, PERIOD);
        model_read(8'h5A);
        wait_read_end();

        // Timeout: busy never rises. The fault appears 32 edges after release.
        busyMode = 1'b0;
        r0 = rdFalls;
        v0 = validCount;
        wait_fall(f2);
        check("start_period_2", f2 - f1, PERIOD);
        n0 = convRises;
        k  = 0;
        while (convRises == n0 && k < 20) begin tick(); k++; end
        e0 = convRiseCyc;
        k  = 0;
        while (!timeoutFault && k < 100) begin tick(); k++; end
        check("timeout_flag", {31'd0, timeoutFault}, 32'd1);
        check("timeout_latency", cyc - e0, TIMEOUT);
        check("timeout_no_read", rdFalls - r0, 0);
        check("timeout_no_valid", validCount - v0, 0);
        model_clear();

        // The next good conversion clears the sticky fault.
        busyMode = 1'b1;
        curData  = 8'h11;
        wait_fall(f3);
        check("start_period_3", f3 - f2, PERIOD);
        check("fault_sticky", {31'd0, timeoutFault}, 32'd1);
        model_read(8'h11);
        wait_read_end();
        check("fault_cleared", {31'd0, timeoutFault}, 32'd0);

        // Drop enable in WAIT_LO. The conversion completes, then no restart.
        curData = 8'h5C;
        wait_fall(f4);
        model_read(8'h5C);
        k = 0;
        while (stateDbg != 3'd3 && k < 100) begin tick(); k++; end
        check("reached_wait_lo", {29'd0, stateDbg}, 32'd3);
        enable = 1'b0;
        wait_read_end();
        n0 = convFalls;
        repeat (150) tick();
        check("no_start_while_disabled", convFalls - n0, 0);

        // The counter is saturated, so re-enabling starts on the next edge.
        curData = 8'hC3;
        c0      = cyc;
        enable  = 1'b1;
        tick();
        check("restart_count", convFalls - n0, 1);
        check("restart_cycle", convFallCyc, c0 + 1);

        // Reset in the first READ cycle aborts the conversion. Nothing is queued for it.
        k = 0;
        while (rd_cs && k < 100) begin tick(); k++; end
        check("reached_read", {31'd0, rd_cs}, 32'd0);
        reset = 1'b1;
        tick();
        check_reset_outputs("abort");
        tick();
        model_clear();
        reset = 1'b0;

        // Four reads 10,20,30,41. With averaging enabled this publishes one
        // value: 101/4 = 25. Without it, each read is published as is.
        for (int i = 0; i < 4; i++) begin
            curData = avgData[i];
            wait_fall(f0);
            if (i == 0) check("post_reset_first_start", f0, PERIOD);
            model_read(avgData[i]);
            wait_read_end();
        end

        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/adc_sample_ctrl.md
ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 Parameter CONV_PERIOD, default 64: minimum clk cycles between successive conversion starts (range 8..255).
REQ-002 Parameter START_WIDTH, default 2: convStart low-pulse width in clk cycles (1..7).
REQ-003 Parameter BUSY_TIMEOUT, default 32: max clk cycles from convStart release to busy falling (4..255).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high permits new conversions to start.
REQ-007 busy  input  1  ADC conversion-in-progress, active high, pre-synchronized.
REQ-008 adcVoltage  input  8  ADC parallel data, valid while rd_cs low.
REQ-009 convStart  output  1  ADC conversion start, active low.
REQ-010 rd_cs  output  1  ADC read/chip-select, active low.
REQ-011 sample  output  8  latest accepted voltage code.
REQ-012 sampleValid  output  1  one-cycle pulse when sample updates.
REQ-013 timeoutFault  output  1  sticky flag: last conversion timed out.

Function
REQ-014 States: IDLE, START, WAIT_HI, WAIT_LO, READ; all outputs registered.
REQ-015 Period counter increments every cycle, saturates at CONV_PERIOD-1, clears to 0 on entry to START.
REQ-016 IDLE -> START when enable=1 and period counter = CONV_PERIOD-1; otherwise stay IDLE.
REQ-017 START: convStart=0 for exactly START_WIDTH cycles, then -> WAIT_HI with convStart=1.
REQ-018 WAIT_HI -> WAIT_LO on first cycle busy=1; WAIT_LO -> READ on first cycle busy=0.
REQ-019 Timeout counter clears on entering WAIT_HI, counts in WAIT_HI/WAIT_LO; at BUSY_TIMEOUT cycles -> IDLE, timeoutFault=1, no sampleValid.
REQ-020 READ: rd_cs=0 for exactly 2 cycles; adcVoltage captured on second cycle; -> IDLE.
REQ-021 Cycle after READ: sample updated, sampleValid=1 for one cycle, timeoutFault cleared.
REQ-022 enable deasserted mid-conversion: current conversion completes normally; no new START until enable=1.
REQ-023 busy already high in WAIT_HI first cycle is accepted; busy toggling outside WAIT_HI/WAIT_LO is ignored.
REQ-024 convStart and rd_cs never simultaneously low.

Reset
REQ-025 reset=1 forces IDLE, convStart=1, rd_cs=1, sample=0, sampleValid=0, timeoutFault=0, all counters 0.
REQ-026 reset mid-conversion aborts immediately; outputs reach reset values on the same clock edge; no sampleValid emitted.

Configuration
REQ-027 Macro ADC_AVG_EN defined: each read adds into 10-bit accumulator; on every 4th read sample = accumulator[9:2], sampleValid pulses, accumulator and read count clear.
REQ-028 ADC_AVG_EN defined: a timeout clears accumulator and read count.
REQ-029 ADC_AVG_EN undefined: every successful read updates sample directly (REQ-021); no accumulator logic present.

Verification
REQ-030 Default params, enable=1 from reset release, ADC model busy high 3 cycles after convStart release for 10 cycles, data 8'hA5 -> convStart low 2 cycles at cycle 63, rd_cs low 2 cycles, sample=8'hA5 with one sampleValid pulse; repeat every 64 cycles.
REQ-031 busy held 0 after convStart -> after 32 cycles timeoutFault=1, no sampleValid, rd_cs never low; next good conversion clears timeoutFault.
REQ-032 enable dropped during WAIT_LO -> conversion completes, sampleValid once, no further convStart until enable reasserted.
REQ-033 reset asserted during READ -> next edge convStart=1, rd_cs=1, sample=0, no sampleValid.
REQ-034 ADC_AVG_EN, data 10,20,30,41 -> single sampleValid after 4th read with sample=25.
REQ-035 All scenarios: convStart and rd_cs never both low (assertion).
